// File: rtl/alien_fire_controller.sv
// Alien shot initiator: picks a pseudo-random column, finds its bottom-most live alien,
// holds a level fire request until the projectile goes in flight, then cools down for N frames.
module alien_fire_controller #(
    parameter int         NUM_COLS        = 8,
    parameter int         NUM_ROWS        = 4,
    parameter logic [9:0] COL_SPACING     = 10'd40,
    parameter logic [9:0] ROW_SPACING     = 10'd30,
    parameter logic [9:0] SHOT_X_OFFSET   = 10'd16,
    parameter logic [9:0] SHOT_Y_OFFSET   = 10'd24,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd60,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic                         enable,
    input  logic [NUM_ROWS*NUM_COLS-1:0] alive_mask,
    input  logic [9:0]                   grid_x,
    input  logic [9:0]                   grid_y,
    input  logic                         missile_active,
    output logic                         shoot,
    output logic [9:0]                   shooter_x,
    output logic [9:0]                   shooter_y,
    output logic [7:0]                   fire_count,
    output logic [2:0]                   state
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COOLDOWN  = 3'd1;
    localparam logic [2:0] WAIT_FREE = 3'd2;
    localparam logic [2:0] PICK      = 3'd3;
    localparam logic [2:0] SCAN      = 3'd4;
    localparam logic [2:0] ARM       = 3'd5;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [ROW_W-1:0] TOP_ROW  = ROW_W'(NUM_ROWS - 1);

    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic             frame_dly;
    logic             frame_edge;
    logic [7:0]       cool_cnt;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] tries;
    logic             cell_alive;
    logic [9:0]       col_off;
    logic [9:0]       row_off;

    // With NUM_COLS a power of two, {row, col} is exactly row*NUM_COLS + col.
    assign cell_alive = alive_mask[{row_q, col_q}];
    assign col_off    = 10'(col_q) * COL_SPACING;
    assign row_off    = 10'(row_q) * ROW_SPACING;
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Handshake: shoot is a level request (valid); missile_active is the acknowledge (ready).
    // shooter_x/y are frozen for as long as shoot is high; the request drops the clock
    // after missile_active is seen in ARM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr       <= LFSR_SEED;
            frame_dly  <= 1'b0;
            frame_edge <= 1'b0;
            state      <= IDLE;
            cool_cnt   <= 8'd0;
            col_q      <= '0;
            row_q      <= '0;
            tries      <= '0;
            shoot      <= 1'b0;
            shooter_x  <= 10'd0;
            shooter_y  <= 10'd0;
            fire_count <= 8'd0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr_fb};
            frame_dly  <= frame_clk;
            frame_edge <= frame_clk & ~frame_dly;

            if (!enable) begin
                state <= IDLE;
                shoot <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cool_cnt <= COOLDOWN_FRAMES;
                        state    <= COOLDOWN;
                    end
                    COOLDOWN: begin
                        if (cool_cnt == 8'd0) begin
                            state <= WAIT_FREE;
                        end else if (frame_edge) begin
                            cool_cnt <= cool_cnt - 8'd1;
                        end
                    end
                    WAIT_FREE: begin
                        if (!missile_active) begin
                            state <= PICK;
                        end
                    end
                    PICK: begin
                        col_q <= lfsr[COL_W-1:0];
                        row_q <= TOP_ROW;
                        tries <= '0;
                        state <= SCAN;
                    end
                    SCAN: begin
                        if (cell_alive) begin
                            shooter_x <= grid_x + col_off + SHOT_X_OFFSET;
                            shooter_y <= grid_y + row_off + SHOT_Y_OFFSET;
                            shoot     <= 1'b1;
                            state     <= ARM;
                        end else if (row_q != '0) begin
                            row_q <= row_q - ROW_W'(1);
                        end else if (tries == LAST_COL) begin
                            // Every column came up empty: skip this shot entirely.
                            cool_cnt <= COOLDOWN_FRAMES;
                            state    <= COOLDOWN;
                        end else begin
                            col_q <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
                            row_q <= TOP_ROW;
                            tries <= tries + COL_W'(1);
                        end
                    end
                    ARM: begin
                        if (missile_active) begin
                            shoot      <= 1'b0;
                            fire_count <= fire_count + 8'd1;
                            cool_cnt   <= COOLDOWN_FRAMES;
                            state      <= COOLDOWN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        shoot <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alien_fire_controller.sv
// Bench for alien_fire_controller: directed scenarios with literal expectations plus a
// per-cycle monitor that checks outputs against a rule-level model of the shot interface.
module tb_alien_fire_controller;

    localparam logic [7:0] COOLDOWN   = 8'd2;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        enable;
    logic [31:0] alive_mask;
    logic [9:0]  grid_x;
    logic [9:0]  grid_y;
    logic        missile_active;
    logic        shoot;
    logic [9:0]  shooter_x;
    logic [9:0]  shooter_y;
    logic [7:0]  fire_count;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;
    int total_frames = 0;
    int exp_count = 0;
    int ack_frame = -100;
    int rises = 0;
    bit frame_on = 1'b1;

    alien_fire_controller #(
        .NUM_COLS(8), .NUM_ROWS(4),
        .COL_SPACING(10'd40), .ROW_SPACING(10'd30),
        .SHOT_X_OFFSET(10'd16), .SHOT_Y_OFFSET(10'd24),
        .COOLDOWN_FRAMES(COOLDOWN), .LFSR_SEED(16'hACE1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .alive_mask(alive_mask), .grid_x(grid_x), .grid_y(grid_y),
        .missile_active(missile_active), .shoot(shoot),
        .shooter_x(shooter_x), .shooter_y(shooter_y),
        .fire_count(fire_count), .state(state)
    );

    // Clock / frame tick generation
    always #5 Clk = ~Clk;

    initial begin
        frame_clk = 1'b0;
        forever begin
            repeat (10) @(posedge Clk);
            #3;
            frame_clk = frame_on ? ~frame_clk : 1'b0;
        end
    end

    always @(posedge frame_clk) total_frames++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A shot is legal if it comes from the bottom-most live alien of some column.
    function automatic bit legal(input int x, input int y, input logic [31:0] m,
                                 input int gx, input int gy);
        for (int c = 0; c < 8; c++) begin
            for (int r = 3; r >= 0; r--) begin
                if (m[r*8+c]) begin
                    if (x == (gx + c*40 + 16) % 1024 && y == (gy + r*30 + 24) % 1024)
                        return 1'b1;
                    break;
                end
            end
        end
        return 1'b0;
    endfunction

    // Scoreboard: inputs seen at one falling edge are what the DUT samples at the next rising edge.
    task automatic monitor();
        bit          have = 1'b0;
        logic        p_reset, p_enable, p_missile, p_shoot;
        logic [31:0] p_mask;
        logic [9:0]  p_gx, p_gy, p_x, p_y;
        forever begin
            @(negedge Clk);
            if (have) begin
                if (p_reset) begin
                    exp_count = 0;
                end else if (p_enable && p_shoot && p_missile) begin
                    exp_count = (exp_count + 1) % 256;
                    ack_frame = total_frames;
                end
                check("fire_count", fire_count, exp_count);
                if (p_reset) begin
                    check("reset_shoot", shoot, 0);
                    check("reset_x", shooter_x, 0);
                    check("reset_y", shooter_y, 0);
                end else if (!p_enable) begin
                    check("disabled_shoot", shoot, 0);
                end else if (p_shoot && p_missile) begin
                    check("ack_drop", shoot, 0);
                end
                if (!p_reset && p_shoot && shoot) begin
                    check("hold_x", shooter_x, p_x);
                    check("hold_y", shooter_y, p_y);
                end
                if (!p_reset && !p_shoot && shoot) begin
                    rises++;
                    check("legal_shot", legal(shooter_x, shooter_y, p_mask, p_gx, p_gy), 1);
                    // One frame edge may already be in the synchroniser when the ack lands.
                    check("cooldown_frames", int'(total_frames - ack_frame >= COOLDOWN - 1), 1);
                end
            end
            have      = 1'b1;
            p_reset   = Reset;
            p_enable  = enable;
            p_missile = missile_active;
            p_mask    = alive_mask;
            p_gx      = grid_x;
            p_gy      = grid_y;
            p_shoot   = shoot;
            p_x       = shooter_x;
            p_y       = shooter_y;
        end
    endtask

    // Driver tasks
    task automatic wait_shoot(input int budget);
        int n = 0;
        while (!shoot && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (!shoot) check("shoot_timeout", 0, 1);
    endtask

    task automatic wait_scan(input int budget);
        int n = 0;
        while (state != ST_SCAN && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (state != ST_SCAN) check("scan_timeout", 0, 1);
    endtask

    task automatic ack(input int n);
        @(posedge Clk); #1 missile_active = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("ack_shoot_low", shoot, 0);
        check("ack_count", fire_count, n);
        repeat (2) @(posedge Clk);
        #1 missile_active = 1'b0;
    endtask

    task automatic shot_at(input string name, input int x, input int y);
        wait_shoot(400);
        check({name, "_x"}, shooter_x, x);
        check({name, "_y"}, shooter_y, y);
    endtask

    task automatic stimulus();
        int r0;
        int len;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Disabled: nothing happens for 100 clocks
        repeat (100) @(posedge Clk);
        @(negedge Clk);
        check("idle_shoot", shoot, 0);
        check("idle_x", shooter_x, 0);
        check("idle_y", shooter_y, 0);
        check("idle_count", fire_count, 0);

        // Single live alien at row 2, col 5
        @(posedge Clk);
        #1 grid_x = 10'd40; grid_y = 10'd60; alive_mask = 32'h1 << 21; enable = 1'b1;
        shot_at("single", 256, 144);
        repeat (500) @(negedge Clk);
        check("held_shoot", shoot, 1);
        check("held_x", shooter_x, 256);
        check("held_y", shooter_y, 144);
        ack(1);

        // Full column 5 with coordinate wrap-around mod 1024
        grid_x = 10'd1000; grid_y = 10'd1000; alive_mask = 32'h2020_2020;
        shot_at("wrap", 192, 90);
        ack(2);

        grid_x = 10'd40; grid_y = 10'd60;
        shot_at("col_full", 256, 174);
        ack(3);
        alive_mask = 32'h0020_2020;
        shot_at("col_bottom_dead", 256, 144);
        ack(4);

        // Enable dropped while a request is pending
        alive_mask = 32'h2020_2020;
        shot_at("pre_disable", 256, 174);
        @(posedge Clk); #1 enable = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("disable_shoot", shoot, 0);
        check("disable_state", state, ST_IDLE);
        check("disable_x_kept", shooter_x, 256);
        check("disable_count_kept", fire_count, 4);

        // Empty grid: full 32-cell scans, never a shot
        @(posedge Clk); #1 alive_mask = 32'h0; enable = 1'b1;
        r0 = rises;
        wait_scan(200);
        len = 0;
        while (state == ST_SCAN && len < 100) begin
            @(negedge Clk);
            len++;
        end
        check("scan_len", len, 32);
        repeat (200) @(negedge Clk);
        check("empty_no_shot", rises, r0);

        // Reset in the middle of a scan
        wait_scan(200);
        repeat (5) @(negedge Clk);
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("midscan_rst_shoot", shoot, 0);
        check("midscan_rst_x", shooter_x, 0);
        check("midscan_rst_y", shooter_y, 0);
        check("midscan_rst_count", fire_count, 0);
        check("midscan_rst_state", state, ST_IDLE);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        enable = 1'b0;
        missile_active = 1'b0;
        alive_mask = 32'h0;
        grid_x = 10'd0;
        grid_y = 10'd0;
        fork
            monitor();
            stimulus();
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
